// File: rtl/pkt_fifo_arbiter_if.sv
// Handshake bundle between the two packet sources, the arbiter and the
// output FIFO write port. The master side drives the sources and the FIFO
// status; the slave side is the arbiter.
interface pkt_fifo_arbiter_if;
  logic [8:0] vid_data;
  logic       vid_valid;
  logic       vid_ready;
  logic [8:0] ctl_data;
  logic       ctl_valid;
  logic       ctl_ready;
  logic [8:0] fifo_data;
  logic       fifo_wr;
  logic       fifo_full;

  modport master (
    output vid_data, vid_valid, ctl_data, ctl_valid, fifo_full,
    input  vid_ready, ctl_ready, fifo_data, fifo_wr
  );

  modport slave (
    input  vid_data, vid_valid, ctl_data, ctl_valid, fifo_full,
    output vid_ready, ctl_ready, fifo_data, fifo_wr
  );
endinterface

// File: rtl/pkt_fifo_arbiter.sv
// Packet-atomic arbiter sharing one 9-bit output-FIFO write port between a
// video source and a control/status source. Bit 8 set marks a payload word,
// 9'h000 terminates a packet. Stalled or overlong packets are closed with an
// arbiter-inserted terminator and flagged in sticky error bits.
module pkt_fifo_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int MAX_LEN = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pkt_fifo_arbiter_if.slave        bus,
  input  logic                     ctl_priority,
  input  logic                     clear_err,
  output logic [1:0]               grant,
  output logic                     timeout_err,
  output logic                     len_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_VID = 2'd1,
    ST_GNT_CTL = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  // Counter values at which the next idle cycle / payload word trips a flush.
  localparam logic [7:0]  IDLE_LAST = 8'(TIMEOUT - 1);
  localparam logic [10:0] LEN_LAST  = 11'(MAX_LEN - 1);

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  idle_cnt_r;
  logic [10:0] len_cnt_r;
  logic        last_ctl_r;      // 1: control was the last owner
  logic        timeout_err_r;
  logic        len_err_r;

  logic        granted_s;
  logic        src_valid_s;
  logic [8:0]  src_data_s;
  logic        accept_s;
  logic        eop_s;
  logic        pay_s;
  logic        len_hit_s;
  logic        idle_tick_s;
  logic        to_hit_s;

  assign timeout_err = timeout_err_r;
  assign len_err     = len_err_r;

  // Select the current owner's word and derive the per-cycle transfer events.
  always_comb begin
    granted_s   = 1'b0;
    src_valid_s = 1'b0;
    src_data_s  = 9'h000;
    case (state_r)
      ST_GNT_VID: begin
        granted_s   = 1'b1;
        src_valid_s = bus.vid_valid;
        src_data_s  = bus.vid_data;
      end
      ST_GNT_CTL: begin
        granted_s   = 1'b1;
        src_valid_s = bus.ctl_valid;
        src_data_s  = bus.ctl_data;
      end
      default: begin
        granted_s   = 1'b0;
        src_valid_s = 1'b0;
        src_data_s  = 9'h000;
      end
    endcase
    accept_s    = granted_s & src_valid_s & ~bus.fifo_full;
    eop_s       = accept_s & ~src_data_s[8];
    pay_s       = accept_s & src_data_s[8];
    len_hit_s   = pay_s & (len_cnt_r == LEN_LAST);
    // Backpressure never counts as idle time.
    idle_tick_s = granted_s & ~src_valid_s & ~bus.fifo_full;
    to_hit_s    = idle_tick_s & (idle_cnt_r == IDLE_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state selection: arbitration in IDLE, packet close or forced flush.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.vid_valid && bus.ctl_valid) begin
          // Tie: priority mode favours control, otherwise alternate owners.
          state_s = (ctl_priority || !last_ctl_r) ? ST_GNT_CTL : ST_GNT_VID;
        end else if (bus.vid_valid) begin
          state_s = ST_GNT_VID;
        end else if (bus.ctl_valid) begin
          state_s = ST_GNT_CTL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GNT_VID, ST_GNT_CTL: begin
        if (eop_s) begin
          state_s = ST_IDLE;
        end else if (len_hit_s || to_hit_s) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = state_r;
        end
      end
      ST_FLUSH: begin
        state_s = bus.fifo_full ? ST_FLUSH : ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Port-facing outputs: combinational pass-through of the owner's word,
  // a zero terminator while flushing, and silence otherwise.
  always_comb begin
    bus.vid_ready = 1'b0;
    bus.ctl_ready = 1'b0;
    bus.fifo_wr   = 1'b0;
    bus.fifo_data = 9'h000;
    grant         = 2'b00;
    case (state_r)
      ST_GNT_VID: begin
        grant         = 2'b01;
        bus.vid_ready = ~bus.fifo_full;
        bus.fifo_wr   = bus.vid_valid & ~bus.fifo_full;
        bus.fifo_data = (bus.vid_valid & ~bus.fifo_full) ? bus.vid_data : 9'h000;
      end
      ST_GNT_CTL: begin
        grant         = 2'b10;
        bus.ctl_ready = ~bus.fifo_full;
        bus.fifo_wr   = bus.ctl_valid & ~bus.fifo_full;
        bus.fifo_data = (bus.ctl_valid & ~bus.fifo_full) ? bus.ctl_data : 9'h000;
      end
      ST_FLUSH: begin
        bus.fifo_wr   = ~bus.fifo_full;
        bus.fifo_data = 9'h000;
      end
      default: begin
        bus.fifo_wr   = 1'b0;
        bus.fifo_data = 9'h000;
      end
    endcase
  end

  // Idle counter: counts stalled cycles of the owner, cleared by any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= 8'd0;
    end else if (!granted_s || accept_s || to_hit_s) begin
      idle_cnt_r <= 8'd0;
    end else if (idle_tick_s) begin
      idle_cnt_r <= idle_cnt_r + 8'd1;
    end
  end

  // Length counter: payload words in the current packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt_r <= 11'd0;
    end else if (!granted_s || eop_s || len_hit_s) begin
      len_cnt_r <= 11'd0;
    end else if (pay_s) begin
      len_cnt_r <= len_cnt_r + 11'd1;
    end
  end

  // Remember who owned the port last; FLUSH only follows a grant state, so
  // recording at packet close also covers the forced-flush case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ctl_r <= 1'b1;
    end else if (eop_s || len_hit_s || to_hit_s) begin
      last_ctl_r <= (state_r == ST_GNT_CTL);
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_r <= 1'b0;
      len_err_r     <= 1'b0;
    end else begin
      if (to_hit_s) begin
        timeout_err_r <= 1'b1;
      end else if (clear_err) begin
        timeout_err_r <= 1'b0;
      end
      if (len_hit_s) begin
        len_err_r <= 1'b1;
      end else if (clear_err) begin
        len_err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_fifo_arbiter.sv
// Directed bench for pkt_fifo_arbiter built with TIMEOUT=4, MAX_LEN=4.
`timescale 1ns/1ps
module tb_pkt_fifo_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ctl_priority = 1'b0;
  logic       clear_err = 1'b0;
  logic [1:0] grant;
  logic       timeout_err;
  logic       len_err;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] wq[$];

  pkt_fifo_arbiter_if bus_i ();

  pkt_fifo_arbiter #(.TIMEOUT(4), .MAX_LEN(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_i),
    .ctl_priority (ctl_priority),
    .clear_err    (clear_err),
    .grant        (grant),
    .timeout_err  (timeout_err),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  // Record every word written to the FIFO (sampled mid-cycle, committed at next edge).
  always @(negedge clk) begin
    if (rst_n && bus_i.fifo_wr) wq.push_back(bus_i.fifo_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_i.vid_valid = 1'b1; bus_i.vid_data = 9'h1FF;
    bus_i.ctl_valid = 1'b1; bus_i.ctl_data = 9'h1EE;
    bus_i.fifo_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
      checks++; if ({bus_i.fifo_wr, bus_i.fifo_data} !== 10'h000) begin errors++; $display("FAIL reset_fifo got %b/%h exp 0/000", bus_i.fifo_wr, bus_i.fifo_data); end
      checks++; if ({bus_i.vid_ready, bus_i.ctl_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {bus_i.vid_ready, bus_i.ctl_ready}); end
      checks++; if ({timeout_err, len_err} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {timeout_err, len_err}); end
      tick();
    end
    bus_i.vid_valid = 1'b0; bus_i.ctl_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_video_pkt();
    logic [8:0] w [4];
    w = '{9'h1FF, 9'h1AA, 9'h100, 9'h000};
    wq.delete();
    bus_i.vid_valid = 1'b1; bus_i.vid_data = w[0];
    #1;
    checks++; if ({grant, bus_i.fifo_wr} !== 3'b000) begin errors++; $display("FAIL vid_idle got grant %b wr %b exp 00 0", grant, bus_i.fifo_wr); end
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL vid_grant got %b exp 01", grant); end
    for (int i = 0; i < 4; i++) begin
      bus_i.vid_data = w[i];
      #1;
      checks++; if ({bus_i.fifo_wr, bus_i.fifo_data} !== {1'b1, w[i]}) begin errors++; $display("FAIL vid_word%0d got %b/%h exp 1/%h", i, bus_i.fifo_wr, bus_i.fifo_data, w[i]); end
      tick();
    end
    bus_i.vid_valid = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL vid_end_idle got %b exp 00", grant); end
    checks++; if (wq.size() !== 4) begin errors++; $display("FAIL vid_count got %0d exp 4", wq.size()); end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      checks++; if (wq[i] !== w[i]) begin errors++; $display("FAIL vid_seq%0d got %h exp %h", i, wq[i], w[i]); end
    end
  endtask

  task automatic test_tie_rr();
    logic [8:0] e [8];
    e = '{9'h1A1, 9'h000, 9'h1C1, 9'h000, 9'h1A2, 9'h000, 9'h1C2, 9'h000};
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    wq.delete();
    bus_i.vid_valid = 1'b1; bus_i.vid_data = 9'h1A1;
    bus_i.ctl_valid = 1'b1; bus_i.ctl_data = 9'h1C1;
    tick();
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_first got %b exp 01", grant); end
    checks++; if (bus_i.ctl_ready !== 1'b0) begin errors++; $display("FAIL rr_ctl_ready got %b exp 0", bus_i.ctl_ready); end
    tick();
    bus_i.vid_data = 9'h000; tick();
    bus_i.vid_valid = 1'b0;
    #1;
    checks++; if ({grant, bus_i.fifo_wr} !== 3'b000) begin errors++; $display("FAIL rr_idle got grant %b wr %b exp 00 0", grant, bus_i.fifo_wr); end
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rr_ctl_next got %b exp 10", grant); end
    tick();
    bus_i.ctl_data = 9'h000; tick();
    bus_i.vid_valid = 1'b1; bus_i.vid_data = 9'h1A2; bus_i.ctl_data = 9'h1C2;
    tick();
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_tie2 got %b exp 01", grant); end
    tick();
    bus_i.vid_data = 9'h000; tick();
    tick();
    #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rr_tie3 got %b exp 10", grant); end
    tick();
    bus_i.ctl_data = 9'h000; tick();
    bus_i.vid_valid = 1'b0; bus_i.ctl_valid = 1'b0;
    #1;
    checks++; if (wq.size() !== 8) begin errors++; $display("FAIL rr_count got %0d exp 8", wq.size()); end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      checks++; if (wq[i] !== e[i]) begin errors++; $display("FAIL rr_seq%0d got %h exp %h", i, wq[i], e[i]); end
    end
  endtask

  task automatic test_ctl_priority();
    wq.delete();
    ctl_priority = 1'b1;
    bus_i.vid_valid = 1'b1; bus_i.vid_data = 9'h1A5;
    bus_i.ctl_valid = 1'b1; bus_i.ctl_data = 9'h1C5;
    tick();
    #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL pri_grant got %b exp 10", grant); end
    checks++; if ({bus_i.vid_ready, bus_i.ctl_ready} !== 2'b01) begin errors++; $display("FAIL pri_ready got %b exp 01", {bus_i.vid_ready, bus_i.ctl_ready}); end
    tick();
    bus_i.ctl_data = 9'h000;
    #1;
    checks++; if (bus_i.vid_ready !== 1'b0) begin errors++; $display("FAIL pri_vid_wait got %b exp 0", bus_i.vid_ready); end
    tick();
    bus_i.ctl_valid = 1'b0;
    #1;
    checks++; if (bus_i.vid_ready !== 1'b0) begin errors++; $display("FAIL pri_vid_idle got %b exp 0", bus_i.vid_ready); end
    tick();
    #1;
    checks++; if ({grant, bus_i.vid_ready} !== 3'b011) begin errors++; $display("FAIL pri_vid_grant got %b/%b exp 01/1", grant, bus_i.vid_ready); end
    tick();
    bus_i.vid_data = 9'h000; tick();
    bus_i.vid_valid = 1'b0; ctl_priority = 1'b0;
    #1;
    checks++; if (wq.size() !== 4 || wq[0] !== 9'h1C5 || wq[2] !== 9'h1A5) begin errors++; $display("FAIL pri_seq got n=%0d exp 1C5,000,1A5,000", wq.size()); end
  endtask

  task automatic test_backpressure();
    wq.delete();
    bus_i.vid_valid = 1'b1; bus_i.vid_data = 9'h1B1;
    tick();
    tick();
    bus_i.vid_valid = 1'b0;
    tick(); tick();
    bus_i.fifo_full = 1'b1; bus_i.vid_data = 9'h1B2;
    for (int i = 0; i < 10; i++) begin
      bus_i.vid_valid = (i >= 5);
      #1;
      checks++; if ({grant, bus_i.fifo_wr, bus_i.vid_ready} !== 4'b0100) begin errors++; $display("FAIL bp_hold%0d got grant %b wr %b rdy %b exp 01 0 0", i, grant, bus_i.fifo_wr, bus_i.vid_ready); end
      tick();
    end
    bus_i.fifo_full = 1'b0; bus_i.vid_valid = 1'b0;
    tick();
    bus_i.vid_valid = 1'b1;
    #1;
    checks++; if ({bus_i.fifo_wr, bus_i.fifo_data} !== {1'b1, 9'h1B2}) begin errors++; $display("FAIL bp_resume got %b/%h exp 1/1B2", bus_i.fifo_wr, bus_i.fifo_data); end
    tick();
    bus_i.vid_data = 9'h000; tick();
    bus_i.vid_valid = 1'b0;
    #1;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL bp_no_timeout got %b exp 0", timeout_err); end
    checks++; if (wq.size() !== 3 || wq[0] !== 9'h1B1 || wq[1] !== 9'h1B2 || wq[2] !== 9'h000) begin errors++; $display("FAIL bp_seq got n=%0d exp 1B1,1B2,000", wq.size()); end
  endtask

  task automatic test_timeout();
    wq.delete();
    bus_i.vid_valid = 1'b1; bus_i.vid_data = 9'h1D1;
    tick();
    tick();
    bus_i.vid_valid = 1'b0;
    bus_i.ctl_valid = 1'b1; bus_i.ctl_data = 9'h1C7;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({grant, bus_i.fifo_wr, bus_i.ctl_ready} !== 4'b0100) begin errors++; $display("FAIL to_wait%0d got grant %b wr %b crdy %b exp 01 0 0", i, grant, bus_i.fifo_wr, bus_i.ctl_ready); end
      tick();
    end
    bus_i.fifo_full = 1'b1;
    #1;
    checks++; if ({grant, bus_i.fifo_wr} !== 3'b000) begin errors++; $display("FAIL to_flush_full got grant %b wr %b exp 00 0", grant, bus_i.fifo_wr); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set got %b exp 1", timeout_err); end
    tick();
    #1;
    checks++; if (bus_i.fifo_wr !== 1'b0) begin errors++; $display("FAIL to_flush_wait got %b exp 0", bus_i.fifo_wr); end
    bus_i.fifo_full = 1'b0;
    #1;
    checks++; if ({bus_i.fifo_wr, bus_i.fifo_data, bus_i.vid_ready} !== {1'b1, 9'h000, 1'b0}) begin errors++; $display("FAIL to_term got %b/%h rdy %b exp 1/000 0", bus_i.fifo_wr, bus_i.fifo_data, bus_i.vid_ready); end
    tick();
    clear_err = 1'b1;
    #1;
    checks++; if ({grant, bus_i.fifo_wr} !== 3'b000) begin errors++; $display("FAIL to_single_term got grant %b wr %b exp 00 0", grant, bus_i.fifo_wr); end
    tick();
    clear_err = 1'b0;
    #1;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", timeout_err); end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_ctl_next got %b exp 10", grant); end
    tick();
    bus_i.ctl_data = 9'h000; tick();
    bus_i.ctl_valid = 1'b0;
    #1;
    checks++; if (wq.size() !== 4 || wq[0] !== 9'h1D1 || wq[1] !== 9'h000 || wq[2] !== 9'h1C7 || wq[3] !== 9'h000) begin errors++; $display("FAIL to_seq got n=%0d exp 1D1,000,1C7,000", wq.size()); end
  endtask

  task automatic test_len_and_reset();
    logic [8:0] e [7];
    e = '{9'h181, 9'h182, 9'h183, 9'h184, 9'h000, 9'h185, 9'h186};
    wq.delete();
    bus_i.vid_valid = 1'b1; bus_i.vid_data = 9'h181;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_i.vid_data = e[i];
      clear_err = (i == 3);
      #1;
      checks++; if ({bus_i.fifo_wr, bus_i.fifo_data} !== {1'b1, e[i]}) begin errors++; $display("FAIL len_word%0d got %b/%h exp 1/%h", i, bus_i.fifo_wr, bus_i.fifo_data, e[i]); end
      tick();
    end
    clear_err = 1'b0; bus_i.vid_data = 9'h185;
    #1;
    checks++; if ({grant, bus_i.fifo_wr, bus_i.fifo_data, bus_i.vid_ready} !== {2'b00, 1'b1, 9'h000, 1'b0}) begin errors++; $display("FAIL len_flush got grant %b wr %b data %h rdy %b exp 00 1 000 0", grant, bus_i.fifo_wr, bus_i.fifo_data, bus_i.vid_ready); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_set got %b exp 1", len_err); end
    tick();
    #1;
    checks++; if ({bus_i.vid_ready, bus_i.fifo_wr, len_err} !== 3'b001) begin errors++; $display("FAIL len_wait got rdy %b wr %b err %b exp 0 0 1", bus_i.vid_ready, bus_i.fifo_wr, len_err); end
    tick();
    #1;
    checks++; if ({grant, bus_i.fifo_data} !== {2'b01, 9'h185}) begin errors++; $display("FAIL len_regrant got %b/%h exp 01/185", grant, bus_i.fifo_data); end
    tick();
    bus_i.vid_data = 9'h186; tick();
    bus_i.vid_data = 9'h187;
    #1;
    checks++; if (bus_i.fifo_wr !== 1'b1) begin errors++; $display("FAIL len_pre_rst got %b exp 1", bus_i.fifo_wr); end
    rst_n = 1'b0;
    #1;
    checks++; if ({grant, bus_i.fifo_wr, bus_i.fifo_data, bus_i.vid_ready, bus_i.ctl_ready} !== 14'h0) begin errors++; $display("FAIL rst_mid got grant %b wr %b data %h rdy %b%b exp all 0", grant, bus_i.fifo_wr, bus_i.fifo_data, bus_i.vid_ready, bus_i.ctl_ready); end
    checks++; if ({timeout_err, len_err} !== 2'b00) begin errors++; $display("FAIL rst_mid_err got %b exp 00", {timeout_err, len_err}); end
    checks++; if (wq.size() !== 7) begin errors++; $display("FAIL len_count got %0d exp 7", wq.size()); end
    for (int i = 0; i < 7 && i < wq.size(); i++) begin
      checks++; if (wq[i] !== e[i]) begin errors++; $display("FAIL len_seq%0d got %h exp %h", i, wq[i], e[i]); end
    end
    bus_i.vid_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus_i.vid_valid = 1'b0; bus_i.vid_data = 9'h000;
    bus_i.ctl_valid = 1'b0; bus_i.ctl_data = 9'h000;
    bus_i.fifo_full = 1'b0;
    test_reset();
    test_video_pkt();
    test_tie_rr();
    test_ctl_priority();
    test_backpressure();
    test_timeout();
    test_len_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
